// File: rtl/cpu6502_interrupt_ctrl_pkg.sv
// Shared encodings for the 6502 interrupt controller: service kinds, vectors, FSM states.
package cpu6502_pkg;

   typedef enum logic [1:0] {
      KIND_NONE  = 2'd0,
      KIND_IRQ   = 2'd1,
      KIND_NMI   = 2'd2,
      KIND_RESET = 2'd3
   } service_kind_e;

   localparam logic [15:0] VEC_NONE  = 16'h0000;
   localparam logic [15:0] VEC_IRQ   = 16'hFFFE;
   localparam logic [15:0] VEC_NMI   = 16'hFFFA;
   localparam logic [15:0] VEC_RESET = 16'hFFFC;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_HOLD    = 2'd2
   } ctrl_state_e;

   function automatic logic [15:0] vector_of(input service_kind_e kind);
      logic [15:0] vec;
      case (kind)
         KIND_IRQ:   vec = VEC_IRQ;
         KIND_NMI:   vec = VEC_NMI;
         KIND_RESET: vec = VEC_RESET;
         default:    vec = VEC_NONE;
      endcase
      return vec;
   endfunction

   // RESET outranks NMI, which outranks IRQ.
   function automatic service_kind_e select_kind(input logic rst_pend, input logic nmi_pend,
                                                 input logic irq_act);
      service_kind_e kind;
      if (rst_pend) begin
         kind = KIND_RESET;
      end else if (nmi_pend) begin
         kind = KIND_NMI;
      end else if (irq_act) begin
         kind = KIND_IRQ;
      end else begin
         kind = KIND_NONE;
      end
      return kind;
   endfunction

endpackage

// File: rtl/cpu6502_interrupt_ctrl_if.sv
// Handshake between the CPU sequencer (master) and the interrupt controller (slave).
interface cpu6502_interrupt_ctrl_if;
   logic        interruptDisableFlag;
   logic        instructionBoundary;
   logic        vectorFetchDone;
   logic        serviceRequest;
   logic [1:0]  serviceKind;
   logic [15:0] vectorAddress;

   modport master (
      output interruptDisableFlag, instructionBoundary, vectorFetchDone,
      input  serviceRequest, serviceKind, vectorAddress
   );

   modport slave (
      input  interruptDisableFlag, instructionBoundary, vectorFetchDone,
      output serviceRequest, serviceKind, vectorAddress
   );
endinterface

// File: rtl/cpu6502_interrupt_ctrl_sync.sv
// Plain flop-chain synchronizer for one asynchronous pin; all stages reset to 1.
module cpu6502_sync #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);
   logic [STAGES-1:0] stage_q;
   logic [STAGES-1:0] stage_d;

   // Shift the pin in at the bottom of the chain.
   always_comb begin
      stage_d = {stage_q[STAGES-2:0], async_in};
   end

   // Stage registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         stage_q <= {STAGES{1'b1}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign sync_out = stage_q[STAGES-1];
endmodule

// File: rtl/cpu6502_interrupt_ctrl.sv
// 6502 interrupt controller: pin sync, NMI edge latch, RESET/NMI/IRQ service FSM.
// Optional CPU6502_NMI_HIJACK_EN lets a pending NMI take over an unacknowledged IRQ request.
module cpu6502_interrupt_ctrl
   import cpu6502_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      interrupt_N,
   input  logic                      nonMaskableInterrupt_N,
   input  logic                      reset_N,
   cpu6502_interrupt_ctrl_if.slave   bus,
   output logic                      coreHold
);
   logic irq_n_s, nmi_n_s, rst_n_s;
   logic irq_active, nmi_edge, nmi_clear;
   service_kind_e pick_kind;

   ctrl_state_e   state_q, state_d;
   service_kind_e kind_q, kind_d;
   logic [15:0]   vector_q, vector_d;
   logic          service_request_q, service_request_d;
   logic          core_hold_q, core_hold_d;
   logic          nmi_pending_q, nmi_pending_d;
   logic          reset_pending_q, reset_pending_d;
   logic          nmi_prev_q, nmi_prev_d;

   cpu6502_sync #(.STAGES(SYNC_STAGES)) u_sync_irq (.clock(clock), .reset(reset), .async_in(interrupt_N),            .sync_out(irq_n_s));
   cpu6502_sync #(.STAGES(SYNC_STAGES)) u_sync_nmi (.clock(clock), .reset(reset), .async_in(nonMaskableInterrupt_N), .sync_out(nmi_n_s));
   cpu6502_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (.clock(clock), .reset(reset), .async_in(reset_N),                .sync_out(rst_n_s));

   // Next-state and registered-output logic.
   always_comb begin
      state_d           = state_q;
      kind_d            = kind_q;
      vector_d          = vector_q;
      service_request_d = service_request_q;
      core_hold_d       = core_hold_q;
      reset_pending_d   = reset_pending_q;
      nmi_clear         = 1'b0;
      nmi_prev_d        = nmi_n_s;
      irq_active        = ~irq_n_s & ~bus.interruptDisableFlag;
      nmi_edge          = nmi_prev_q & ~nmi_n_s;
      pick_kind         = select_kind(reset_pending_q, nmi_pending_q, irq_active);

      if (!rst_n_s) begin
         // Held reset pin wins over enable and every other input.
         state_d           = ST_HOLD;
         kind_d            = KIND_NONE;
         vector_d          = VEC_NONE;
         service_request_d = 1'b0;
         core_hold_d       = 1'b1;
         reset_pending_d   = 1'b1;
      end else if (enable) begin
         core_hold_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.instructionBoundary && (pick_kind != KIND_NONE)) begin
                  state_d           = ST_REQUEST;
                  kind_d            = pick_kind;
                  vector_d          = vector_of(pick_kind);
                  service_request_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_REQUEST: begin
               if (bus.vectorFetchDone) begin
                  state_d           = ST_IDLE;
                  kind_d            = KIND_NONE;
                  vector_d          = VEC_NONE;
                  service_request_d = 1'b0;
                  nmi_clear         = (kind_q == KIND_NMI);
                  reset_pending_d   = (kind_q == KIND_RESET) ? 1'b0 : reset_pending_q;
               end
`ifdef CPU6502_NMI_HIJACK_EN
               else if ((kind_q == KIND_IRQ) && nmi_pending_q) begin
                  kind_d   = KIND_NMI;
                  vector_d = VEC_NMI;
               end
`endif
               else begin
                  kind_d = kind_q;
               end
            end
            ST_HOLD: begin
               state_d           = ST_REQUEST;
               kind_d            = KIND_RESET;
               vector_d          = VEC_RESET;
               service_request_d = 1'b1;
            end
            default: begin
               state_d           = ST_IDLE;
               kind_d            = KIND_NONE;
               vector_d          = VEC_NONE;
               service_request_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // A fresh edge beats a same-cycle acknowledge.
      if (nmi_edge) begin
         nmi_pending_d = 1'b1;
      end else if (nmi_clear) begin
         nmi_pending_d = 1'b0;
      end else begin
         nmi_pending_d = nmi_pending_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         kind_q            <= KIND_NONE;
         vector_q          <= VEC_NONE;
         service_request_q <= 1'b0;
         core_hold_q       <= 1'b0;
         nmi_pending_q     <= 1'b0;
         reset_pending_q   <= 1'b1;
         nmi_prev_q        <= 1'b1;
      end else begin
         state_q           <= state_d;
         kind_q            <= kind_d;
         vector_q          <= vector_d;
         service_request_q <= service_request_d;
         core_hold_q       <= core_hold_d;
         nmi_pending_q     <= nmi_pending_d;
         reset_pending_q   <= reset_pending_d;
         nmi_prev_q        <= nmi_prev_d;
      end
   end

   assign bus.serviceRequest = service_request_q;
   assign bus.serviceKind    = kind_q;
   assign bus.vectorAddress  = vector_q;
   assign coreHold           = core_hold_q;
endmodule

// File: tb/tb_cpu6502_interrupt_ctrl.sv
// Self-checking bench: directed scenarios followed by random traffic, against a cycle reference model.
module tb_cpu6502_interrupt_ctrl;
   localparam int S = 2;

   logic clock = 1'b0;
   logic reset, enable, interrupt_N, nonMaskableInterrupt_N, reset_N, coreHold;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   rst_low_cnt = 0;

   cpu6502_interrupt_ctrl_if bus ();

   cpu6502_interrupt_ctrl #(.SYNC_STAGES(S)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .interrupt_N(interrupt_N), .nonMaskableInterrupt_N(nonMaskableInterrupt_N),
      .reset_N(reset_N), .bus(bus), .coreHold(coreHold)
   );

   always #5 clock = ~clock;

   // Reference model: pin pipelines, pending latches and the current service.
   bit p_irq [S];
   bit p_nmi [S];
   bit p_rst [S];
   bit m_prev, m_busy, m_hold, m_sr, m_core, m_nmi_pend, m_rst_pend;
   int m_kind;

   function automatic logic [15:0] exp_vector(input int k);
      if (k == 1) return 16'hFFFE;
      if (k == 2) return 16'hFFFA;
      if (k == 3) return 16'hFFFC;
      return 16'h0000;
   endfunction

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_step();
      bit s_irq, s_nmi, s_rst, edge_seen, clear_nmi;
      if (reset) begin
         for (int i = 0; i < S; i++) begin p_irq[i] = 1; p_nmi[i] = 1; p_rst[i] = 1; end
         m_prev = 1; m_busy = 0; m_hold = 0; m_sr = 0; m_core = 0;
         m_nmi_pend = 0; m_rst_pend = 1; m_kind = 0;
         return;
      end
      s_irq = p_irq[S-1]; s_nmi = p_nmi[S-1]; s_rst = p_rst[S-1];
      edge_seen = m_prev && !s_nmi;
      clear_nmi = 0;
      if (!s_rst) begin
         m_hold = 1; m_busy = 0; m_sr = 0; m_kind = 0; m_rst_pend = 1; m_core = 1;
      end else if (enable) begin
         m_core = 0;
         if (m_hold) begin
            m_hold = 0; m_busy = 1; m_sr = 1; m_kind = 3;
         end else if (m_busy) begin
            if (bus.vectorFetchDone) begin
               if (m_kind == 2) clear_nmi = 1;
               if (m_kind == 3) m_rst_pend = 0;
               m_busy = 0; m_sr = 0; m_kind = 0;
            end
`ifdef CPU6502_NMI_HIJACK_EN
            else if (m_kind == 1 && m_nmi_pend) m_kind = 2;
`endif
         end else if (bus.instructionBoundary) begin
            if (m_rst_pend) m_kind = 3;
            else if (m_nmi_pend) m_kind = 2;
            else if (!s_irq && !bus.interruptDisableFlag) m_kind = 1;
            if (m_kind != 0) begin m_busy = 1; m_sr = 1; end
         end
      end
      if (edge_seen) m_nmi_pend = 1;
      else if (clear_nmi) m_nmi_pend = 0;
      m_prev = s_nmi;
      for (int i = S - 1; i > 0; i--) begin
         p_irq[i] = p_irq[i-1]; p_nmi[i] = p_nmi[i-1]; p_rst[i] = p_rst[i-1];
      end
      p_irq[0] = interrupt_N; p_nmi[0] = nonMaskableInterrupt_N; p_rst[0] = reset_N;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_value("serviceRequest", {31'd0, bus.serviceRequest}, {31'd0, m_sr});
      check_value("serviceKind", {30'd0, bus.serviceKind}, m_kind);
      check_value("vectorAddress", {16'd0, bus.vectorAddress}, {16'd0, exp_vector(m_kind)});
      check_value("coreHold", {31'd0, coreHold}, {31'd0, m_core});
   endtask

   task automatic set_bus(input logic b, input logic v);
      bus.instructionBoundary = b;
      bus.vectorFetchDone     = v;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; interrupt_N = 1'b1; nonMaskableInterrupt_N = 1'b1; reset_N = 1'b1;
      bus.interruptDisableFlag = 1'b0;
      set_bus(1'b0, 1'b0);
      tick(); tick();
      reset = 1'b0;

      // First boundary after reset issues RESET.
      set_bus(1'b1, 1'b0); tick();
      check_value("reset_first_kind", {30'd0, bus.serviceKind}, 32'd3);
      check_value("reset_first_vec", {16'd0, bus.vectorAddress}, 32'h0000FFFC);
      set_bus(1'b0, 1'b0); tick();
      set_bus(1'b0, 1'b1); tick();
      set_bus(1'b0, 1'b0); tick();

      // IRQ unmasked then masked.
      interrupt_N = 1'b0; repeat (3) tick();
      set_bus(1'b1, 1'b0); tick();
      check_value("irq_kind", {30'd0, bus.serviceKind}, 32'd1);
      set_bus(1'b0, 1'b1); tick();
      bus.interruptDisableFlag = 1'b1;
      set_bus(1'b1, 1'b0); tick();
      check_value("irq_masked", {31'd0, bus.serviceRequest}, 32'd0);
      set_bus(1'b0, 1'b0); interrupt_N = 1'b1; bus.interruptDisableFlag = 1'b0; repeat (3) tick();

      // NMI pulse, late boundary, then no repeat without a new edge.
      nonMaskableInterrupt_N = 1'b0; repeat (3) tick();
      nonMaskableInterrupt_N = 1'b1; repeat (10) tick();
      set_bus(1'b1, 1'b0); tick();
      check_value("nmi_kind", {30'd0, bus.serviceKind}, 32'd2);
      set_bus(1'b0, 1'b1); tick();
      set_bus(1'b1, 1'b0); tick();
      check_value("nmi_no_repeat", {31'd0, bus.serviceRequest}, 32'd0);
      set_bus(1'b0, 1'b0);

      // NMI and IRQ together: NMI first, then IRQ.
      interrupt_N = 1'b0; nonMaskableInterrupt_N = 1'b0; repeat (4) tick();
      nonMaskableInterrupt_N = 1'b1;
      set_bus(1'b1, 1'b0); tick();
      check_value("prio_nmi", {30'd0, bus.serviceKind}, 32'd2);
      set_bus(1'b0, 1'b1); tick();
      set_bus(1'b1, 1'b0); tick();
      check_value("prio_irq_next", {30'd0, bus.serviceKind}, 32'd1);
      set_bus(1'b0, 1'b1); tick();
      set_bus(1'b0, 1'b0); interrupt_N = 1'b1; repeat (3) tick();

      // NMI edge while an IRQ request is outstanding.
      interrupt_N = 1'b0; repeat (3) tick();
      set_bus(1'b1, 1'b0); tick();
      set_bus(1'b0, 1'b0); nonMaskableInterrupt_N = 1'b0; repeat (4) tick();
`ifdef CPU6502_NMI_HIJACK_EN
      check_value("hijack_kind", {30'd0, bus.serviceKind}, 32'd2);
`else
      check_value("frozen_kind", {30'd0, bus.serviceKind}, 32'd1);
`endif
      set_bus(1'b0, 1'b1); tick();
      nonMaskableInterrupt_N = 1'b1; interrupt_N = 1'b1;
      set_bus(1'b1, 1'b0); tick();
      set_bus(1'b0, 1'b1); tick();
      set_bus(1'b0, 1'b0); repeat (3) tick();

      // reset_N mid-request, then release without a boundary.
      interrupt_N = 1'b0; repeat (3) tick();
      set_bus(1'b1, 1'b0); tick();
      set_bus(1'b0, 1'b0); reset_N = 1'b0; repeat (4) tick();
      check_value("hold_core", {31'd0, coreHold}, 32'd1);
      check_value("hold_no_req", {31'd0, bus.serviceRequest}, 32'd0);
      reset_N = 1'b1; repeat (4) tick();
      check_value("release_kind", {30'd0, bus.serviceKind}, 32'd3);
      set_bus(1'b0, 1'b1); tick();
      set_bus(1'b0, 1'b0); interrupt_N = 1'b1; tick();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         reset  = ($urandom_range(499) == 0);
         enable = ($urandom_range(99) < 85);
         if ($urandom_range(9) == 0)  interrupt_N = ~interrupt_N;
         if ($urandom_range(29) == 0) nonMaskableInterrupt_N = ~nonMaskableInterrupt_N;
         if ($urandom_range(19) == 0) bus.interruptDisableFlag = ~bus.interruptDisableFlag;
         if (rst_low_cnt > 0) begin
            rst_low_cnt--;
            reset_N = (rst_low_cnt == 0);
         end else if ($urandom_range(199) == 0) begin
            rst_low_cnt = $urandom_range(8, 2);
            reset_N = 1'b0;
         end
         set_bus($urandom_range(99) < 40, $urandom_range(99) < 30);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cpu6502_interrupt_ctrl.md
CPU6502_INTERRUPT_CTRL -- requirements
Module: cpu6502_interrupt_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, pin synchronizer depth (legal values 2 or 3).
REQ-002 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high core reset.
REQ-004 SHALL have port enable  input  1  clock enable for the state machine; low freezes state and outputs.
REQ-005 SHALL have ports interrupt_N, nonMaskableInterrupt_N, reset_N  input  1 each  asynchronous active-low CPU pins.
REQ-006 SHALL have port interruptDisableFlag  input  1  processor I flag.
REQ-007 SHALL have port instructionBoundary  input  1  high when the FSM is in DECODE.
REQ-008 SHALL have port vectorFetchDone  input  1  single-cycle acknowledge from the FSM after the vector high byte is read.
REQ-009 SHALL have port serviceRequest  output  1  interrupt sequence requested; the FSM diverts from opcode dispatch.
REQ-010 SHALL have port serviceKind  output  2  0 NONE, 1 IRQ, 2 NMI, 3 RESET.
REQ-011 SHALL have port vectorAddress  output  16  IRQ 16'hFFFE, NMI 16'hFFFA, RESET 16'hFFFC, NONE 16'h0000.
REQ-012 SHALL have port coreHold  output  1  high while the reset_N pin is held low.

Function
REQ-013 Each pin SHALL pass through a SYNC_STAGES flop synchronizer before use, with no other logic in the synchronizer path.
REQ-014 A synchronized NMI high-to-low transition SHALL set nmiPending one cycle after the synchronizer output falls, independent of enable.
REQ-015 IRQ SHALL be level-sensitive: irqActive = synchronized interrupt_N low AND interruptDisableFlag low; IRQ SHALL NOT be latched.
REQ-016 States SHALL be IDLE, REQUEST and HOLD; transitions occur only when enable is high, except forced entry to HOLD.
REQ-017 Synchronized reset_N low SHALL force HOLD from any state, set resetPending, assert coreHold and deassert serviceRequest.
REQ-018 HOLD SHALL go to REQUEST with kind RESET on the first enabled cycle after synchronized reset_N returns high, without waiting for instructionBoundary.
REQ-019 IDLE SHALL go to REQUEST when instructionBoundary is high and any source is pending; priority is RESET > NMI > IRQ, and the kind is captured at the transition.
REQ-020 In REQUEST, serviceRequest SHALL be 1; serviceKind and vectorAddress SHALL stay stable until exit.
REQ-021 REQUEST SHALL go to IDLE on vectorFetchDone and clear the pending latch of the captured kind; IRQ clears nothing.
REQ-022 A new NMI edge coincident with the vectorFetchDone that clears nmiPending SHALL leave nmiPending set (set wins).
REQ-023 vectorFetchDone in IDLE or HOLD SHALL be ignored.
REQ-024 IRQ deasserting while in REQUEST SHALL NOT cancel the request.
REQ-025 Outputs SHALL be registered; latency from the enabled instructionBoundary cycle to serviceRequest high is 1 cycle.

Reset
REQ-026 reset SHALL set state IDLE, serviceRequest 0, serviceKind 0, vectorAddress 0, coreHold 0, nmiPending 0, resetPending 1, and all synchronizer flops 1.
REQ-027 reset SHALL override enable and all other inputs in the same cycle; the first boundary after reset SHALL issue a RESET service.

Configuration
REQ-028 With CPU6502_NMI_HIJACK_EN defined, nmiPending set while in REQUEST with kind IRQ and no vectorFetchDone that cycle SHALL switch kind to NMI and vectorAddress to 16'hFFFA on the next cycle; the subsequent vectorFetchDone clears nmiPending.
REQ-029 Without CPU6502_NMI_HIJACK_EN, kind SHALL stay frozen in REQUEST and NMI is serviced at the next boundary.

Structure
REQ-030 Package cpu6502_pkg SHALL hold the serviceKind encodings, the three vector constants and the state encoding.
REQ-031 Sub-module cpu6502_sync (parameterized synchronizer, reset value 1) SHALL be instantiated once per pin.

Verification
REQ-032 After reset, enable=1, boundary=1: serviceRequest at cycle +1, kind=3, vector=FFFC; vectorFetchDone -> IDLE, resetPending=0.
REQ-033 interrupt_N low, I=0, boundary -> kind=1, vector=FFFE; same with I=1 -> no request.
REQ-034 NMI pulse low for 3 cycles, then boundary 10 cycles later -> kind=2, vector=FFFA; a second boundary without a new edge -> no request.
REQ-035 NMI and IRQ pending together at a boundary -> NMI first; after ack with IRQ still low -> IRQ at next boundary.
REQ-036 IRQ in REQUEST, NMI edge arrives: with macro -> kind becomes 2 before ack; without macro -> kind stays 1, NMI follows.
REQ-037 reset_N low mid-REQUEST -> coreHold=1, serviceRequest=0; release -> RESET request with no boundary needed.
